versat_rr_merge: RTL and testbench
==================================

Name: versat_rr_merge

Overview:
- Parametrised successor to the Versat databus merge stage. Funnels N_SLAVES unit databus ports (valid/ready/last bursts) onto one simple write channel and one simple read channel, which feed the simple-to-AXI bridge.
- Adds fair round-robin arbitration per channel (independent write and read pointers), a configurable burst-length width and grant/busy visibility outputs.
- Holds each grant locked until the burst's last beat completes.

Parameters:
- N_SLAVES, 2, number of databus ports (>=1).
- ADDR_W, 32, address width per port.
- DATA_W, 32, data width; multiple of 8.
- LEN_W, 8, burst length width (beats-1 encoding, AXI style).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
- s_valid  in  N_SLAVES  per-port request valid.
- s_ready  out  N_SLAVES  per-port beat accepted/returned.
- s_last  out  N_SLAVES  per-port last beat of burst.
- s_addr  in  N_SLAVES*ADDR_W  packed addresses, port g at [g*ADDR_W +: ADDR_W].
- s_wdata  in  N_SLAVES*DATA_W  packed write data.
- s_wstrb  in  N_SLAVES*DATA_W/8  packed strobes; any bit set marks a write request.
- s_len  in  N_SLAVES*LEN_W  packed burst lengths.
- s_rdata  out  DATA_W  shared read data (= m_rdata).
- m_wvalid / m_wready  out/in  1  write channel handshake.
- m_waddr, m_wdata, m_wstrb, m_wlen  out  ADDR_W, DATA_W, DATA_W/8, LEN_W  write request fields.
- m_wlast  in  1  last write beat from downstream.
- m_rvalid / m_rready  out/in  1  read channel handshake.
- m_raddr, m_rlen  out  ADDR_W, LEN_W  read request fields.
- m_rdata  in  DATA_W  read data.
- m_rlast  in  1  last read beat.
- w_busy, r_busy  out  1  channel currently locked to a port.
- w_grant, r_grant  out  N_SLAVES  one-hot owner of each channel (0 when idle).

Behaviour:
- Request classification:
  - w_req[i] = s_valid[i] & |wstrb[i].
  - r_req[i] = s_valid[i] & ~|wstrb[i].
  - A port currently owning one channel is masked out of the other channel's request vector.
- Per-channel state: IDLE and BUSY, with registers owner and ptr (index width max(1,$clog2(N_SLAVES))).
- IDLE:
  - If any request is present, grant the first requester searching ptr, ptr+1, ... cyclically (mod N_SLAVES).
  - Next cycle: BUSY, owner <= grantee, ptr <= (grantee+1) mod N_SLAVES.
  - Latency from request to downstream valid is 1 cycle.
- BUSY:
  - m_*valid = s_valid[owner]; address, len, wdata and wstrb are taken from owner.
  - s_ready[owner] = m_*ready; s_last[owner] = m_*last.
  - On m_*valid & m_*ready & m_*last: return to IDLE.
  - A new grant is possible the following cycle, so bursts are never granted back-to-back in the same cycle.
- Outputs are zero when the channel is IDLE: m_*valid, m_waddr, m_wdata, m_wstrb, m_wlen, m_raddr, m_rlen, the grant vector and busy.
- s_ready and s_last are the bitwise OR of the write-owner and read-owner contributions.
- s_rdata is always m_rdata, combinational.
- Write and read channels are fully independent. Simultaneous grants to two different ports in the same cycle are legal.
- A port that drops s_valid mid-burst keeps the lock. m_*valid falls with it, and the burst resumes when valid returns.
- The last beat is defined only by downstream m_*last. The merge does not count beats.
- Reset (rst=0, any time including mid-burst), asynchronous:
  - Both channels go to IDLE; owner=0, ptr=0.
  - All outputs go to 0 immediately, except s_rdata.
- N_SLAVES=1: the arbiter degenerates to always granting port 0. ptr stays 0.

Decomposition:
- Shared package versat_merge_pkg holds:
  - localparam IDX_W = max(1,$clog2(N_SLAVES)) helper function.
  - channel state encoding IDLE=1'b0, BUSY=1'b1.
- Sub-module versat_rr_arbiter (N, req vector, ptr in) gives a combinational grant index and valid. It is instantiated once per channel.

Test Plan:
- N=4; ports 0,2,3 request writes continuously with len=0, m_wlast tied 1. Grants must be 0,2,3,0,2,… with one IDLE cycle between bursts.
- Port 1 write len=3 and port 2 read len=1, both valid at cycle 5. Both channels go BUSY at cycle 6; w_grant=0010, r_grant=0100. s_ready=0110 while both downstream readies are high.
- Hold m_wready=0 for 3 cycles mid-burst. m_wvalid stays 1, s_ready[owner] stays 0, and the grant does not change.
- Port 0 drops s_valid on beat 2 of 4. m_wvalid=0 and the lock is kept. When valid reasserts the burst finishes, and IDLE follows the m_wlast transfer.
- Assert rst=0 mid read burst. r_busy, m_rvalid, r_grant and s_ready go to 0 asynchronously. After release, the first grant goes to the lowest-index requester (ptr=0).
- Port 3 is write-owner while also presenting a read request (wstrb changed to 0). The read request is ignored until the write burst ends.

Source files
------------

// File: rtl/versat_merge_pkg.sv
// Shared types and helpers for the Versat databus merge stage.
// Channel state encoding and index-width sizing used by the merge and its arbiter.
package versat_merge_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } ch_state_t;

   // A one-port merge still needs a 1-bit index register.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/versat_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, cyclically; purely combinational.
// Zero latency; no backpressure, the caller decides when the pick is taken.
module versat_rr_arbiter
   import versat_merge_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = idx_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             gnt_vld,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [31:0] j;

   // Scan from the far end so the candidate closest to ptr is assigned last and wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      j       = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (32'(ptr) + 32'(k)) % 32'(N);
         if (req[j]) begin
            gnt_vld = 1'b1;
            gnt_idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/versat_rr_merge.sv
// Merges N databus ports onto one write and one read channel, round-robin per channel, grant held until last beat.
// 1 cycle request-to-valid; backpressure passes straight through (s_ready = m_*ready for the owner).
module versat_rr_merge
   import versat_merge_pkg::*;
#(
   parameter int N_SLAVES = 2,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LEN_W    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_SLAVES-1:0]          s_valid,
   output logic [N_SLAVES-1:0]          s_ready,
   output logic [N_SLAVES-1:0]          s_last,
   input  logic [N_SLAVES*ADDR_W-1:0]   s_addr,
   input  logic [N_SLAVES*DATA_W-1:0]   s_wdata,
   input  logic [N_SLAVES*DATA_W/8-1:0] s_wstrb,
   input  logic [N_SLAVES*LEN_W-1:0]    s_len,
   output logic [DATA_W-1:0]            s_rdata,
   output logic                         m_wvalid,
   input  logic                         m_wready,
   output logic [ADDR_W-1:0]            m_waddr,
   output logic [DATA_W-1:0]            m_wdata,
   output logic [DATA_W/8-1:0]          m_wstrb,
   output logic [LEN_W-1:0]             m_wlen,
   input  logic                         m_wlast,
   output logic                         m_rvalid,
   input  logic                         m_rready,
   output logic [ADDR_W-1:0]            m_raddr,
   output logic [LEN_W-1:0]             m_rlen,
   input  logic [DATA_W-1:0]            m_rdata,
   input  logic                         m_rlast,
   output logic                         w_busy,
   output logic                         r_busy,
   output logic [N_SLAVES-1:0]          w_grant,
   output logic [N_SLAVES-1:0]          r_grant
);

   localparam int IDX_W = idx_w(N_SLAVES);
   localparam int SW    = DATA_W / 8;

   ch_state_t             w_state, w_state_nxt, r_state, r_state_nxt;
   logic [IDX_W-1:0]      w_owner, w_owner_nxt, w_ptr, w_ptr_nxt;
   logic [IDX_W-1:0]      r_owner, r_owner_nxt, r_ptr, r_ptr_nxt;
   logic [N_SLAVES-1:0]   w_req, r_req, w_rdy_vec, r_rdy_vec, w_last_vec, r_last_vec;
   logic                  w_gnt_vld, r_gnt_vld;
   logic [IDX_W-1:0]      w_gnt_idx, r_gnt_idx;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
      return IDX_W'((32'(i) + 32'd1) % 32'(N_SLAVES));
   endfunction

   // A port that owns one channel cannot open a burst on the other.
   always_comb begin
      w_req = '0;
      r_req = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         w_req[i] = s_valid[i] &  (|s_wstrb[i*SW +: SW]) & ~r_grant[i];
         r_req[i] = s_valid[i] & ~(|s_wstrb[i*SW +: SW]) & ~w_grant[i];
      end
   end

   versat_rr_arbiter #(.N(N_SLAVES), .IDX_W(IDX_W)) u_w_arb (
      .req(w_req), .ptr(w_ptr), .gnt_vld(w_gnt_vld), .gnt_idx(w_gnt_idx)
   );

   versat_rr_arbiter #(.N(N_SLAVES), .IDX_W(IDX_W)) u_r_arb (
      .req(r_req), .ptr(r_ptr), .gnt_vld(r_gnt_vld), .gnt_idx(r_gnt_idx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_state <= IDLE;
         w_owner <= '0;
         w_ptr   <= '0;
         r_state <= IDLE;
         r_owner <= '0;
         r_ptr   <= '0;
      end else begin
         w_state <= w_state_nxt;
         w_owner <= w_owner_nxt;
         w_ptr   <= w_ptr_nxt;
         r_state <= r_state_nxt;
         r_owner <= r_owner_nxt;
         r_ptr   <= r_ptr_nxt;
      end
   end

   // Burst end is whatever downstream flags as last; beats are never counted here.
   always_comb begin
      w_state_nxt = w_state;
      w_owner_nxt = w_owner;
      w_ptr_nxt   = w_ptr;
      r_state_nxt = r_state;
      r_owner_nxt = r_owner;
      r_ptr_nxt   = r_ptr;
      case (w_state)
         IDLE: if (w_gnt_vld) begin
            w_state_nxt = BUSY;
            w_owner_nxt = w_gnt_idx;
            w_ptr_nxt   = wrap_inc(w_gnt_idx);
         end
         BUSY: if (m_wvalid && m_wready && m_wlast) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      case (r_state)
         IDLE: if (r_gnt_vld) begin
            r_state_nxt = BUSY;
            r_owner_nxt = r_gnt_idx;
            r_ptr_nxt   = wrap_inc(r_gnt_idx);
         end
         BUSY: if (m_rvalid && m_rready && m_rlast) r_state_nxt = IDLE;
         default: r_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_busy     = (w_state == BUSY);
      r_busy     = (r_state == BUSY);
      m_wvalid   = 1'b0;
      m_waddr    = '0;
      m_wdata    = '0;
      m_wstrb    = '0;
      m_wlen     = '0;
      w_grant    = '0;
      w_rdy_vec  = '0;
      w_last_vec = '0;
      m_rvalid   = 1'b0;
      m_raddr    = '0;
      m_rlen     = '0;
      r_grant    = '0;
      r_rdy_vec  = '0;
      r_last_vec = '0;
      if (w_busy) begin
         m_wvalid            = s_valid[w_owner];
         m_waddr             = s_addr[w_owner*ADDR_W +: ADDR_W];
         m_wdata             = s_wdata[w_owner*DATA_W +: DATA_W];
         m_wstrb             = s_wstrb[w_owner*SW +: SW];
         m_wlen              = s_len[w_owner*LEN_W +: LEN_W];
         w_grant[w_owner]    = 1'b1;
         w_rdy_vec[w_owner]  = m_wready;
         w_last_vec[w_owner] = m_wlast;
      end
      if (r_busy) begin
         m_rvalid            = s_valid[r_owner];
         m_raddr             = s_addr[r_owner*ADDR_W +: ADDR_W];
         m_rlen              = s_len[r_owner*LEN_W +: LEN_W];
         r_grant[r_owner]    = 1'b1;
         r_rdy_vec[r_owner]  = m_rready;
         r_last_vec[r_owner] = m_rlast;
      end
   end

   assign s_ready = w_rdy_vec | r_rdy_vec;
   assign s_last  = w_last_vec | r_last_vec;
   assign s_rdata = m_rdata;

endmodule

// File: tb/tb_versat_rr_merge.sv
// Bench for versat_rr_merge with four ports: table vectors, corner sequences, random run against a reference model.
module tb_versat_rr_merge;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 8;
   localparam int SW = DW / 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    s_valid, s_ready, s_last;
   logic [N*AW-1:0] s_addr;
   logic [N*DW-1:0] s_wdata;
   logic [N*SW-1:0] s_wstrb;
   logic [N*LW-1:0] s_len;
   logic [DW-1:0]   s_rdata;
   logic            m_wvalid, m_wready, m_wlast;
   logic [AW-1:0]   m_waddr;
   logic [DW-1:0]   m_wdata;
   logic [SW-1:0]   m_wstrb;
   logic [LW-1:0]   m_wlen;
   logic            m_rvalid, m_rready, m_rlast;
   logic [AW-1:0]   m_raddr;
   logic [LW-1:0]   m_rlen;
   logic [DW-1:0]   m_rdata;
   logic            w_busy, r_busy;
   logic [N-1:0]    w_grant, r_grant;

   int errors = 0;
   int checks = 0;
   logic [LW-1:0] lens [N];

   typedef struct packed {
      logic [N-1:0] v, wm;
      logic         wr, wl, rr, rl;
      logic [N-1:0] eg, erg, erdy, elast;
   } vec_t;
   vec_t tbl [14];

   always #5 clk = ~clk;

   versat_rr_merge #(.N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_len(s_len), .s_rdata(s_rdata),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_waddr(m_waddr), .m_wdata(m_wdata),
      .m_wstrb(m_wstrb), .m_wlen(m_wlen), .m_wlast(m_wlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_raddr(m_raddr), .m_rlen(m_rlen),
      .m_rdata(m_rdata), .m_rlast(m_rlast),
      .w_busy(w_busy), .r_busy(r_busy), .w_grant(w_grant), .r_grant(r_grant)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] port_addr(input int i);
      return 32'hA000_0000 + 32'(i) * 32'h100;
   endfunction

   function automatic int oh2i(input logic [N-1:0] oh);
      for (int i = 0; i < N; i++) if (oh[i]) return i;
      return -1;
   endfunction

   function automatic int pick(input logic [N-1:0] req, input int ptr);
      for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] wm,
                        input logic wr, input logic wl, input logic rr, input logic rl);
      s_valid = v;
      for (int i = 0; i < N; i++) s_wstrb[i*SW +: SW] = wm[i] ? {SW{1'b1}} : '0;
      m_wready = wr;
      m_wlast  = wl;
      m_rready = rr;
      m_rlast  = rl;
   endtask

   task automatic load_ports();
      for (int i = 0; i < N; i++) begin
         s_addr[i*AW +: AW]  = port_addr(i);
         s_wdata[i*DW +: DW] = 32'hD000_0000 + 32'(i);
         s_len[i*LW +: LW]   = lens[i];
      end
   endtask

   task automatic do_reset();
      drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic run_vec(input int idx);
      vec_t t;
      int   wo, ro;
      t = tbl[idx];
      drive(t.v, t.wm, t.wr, t.wl, t.rr, t.rl);
      #2;
      wo = oh2i(t.eg);
      ro = oh2i(t.erg);
      chk($sformatf("v%0d w_grant", idx), w_grant, t.eg);
      chk($sformatf("v%0d r_grant", idx), r_grant, t.erg);
      chk($sformatf("v%0d s_ready", idx), s_ready, t.erdy);
      chk($sformatf("v%0d s_last", idx), s_last, t.elast);
      chk($sformatf("v%0d w_busy", idx), w_busy, |t.eg);
      chk($sformatf("v%0d r_busy", idx), r_busy, |t.erg);
      chk($sformatf("v%0d m_wvalid", idx), m_wvalid, |(t.v & t.eg));
      chk($sformatf("v%0d m_rvalid", idx), m_rvalid, |(t.v & t.erg));
      chk($sformatf("v%0d m_waddr", idx), m_waddr, (wo < 0) ? '0 : port_addr(wo));
      chk($sformatf("v%0d m_wlen", idx), m_wlen, (wo < 0) ? '0 : lens[wo]);
      chk($sformatf("v%0d m_raddr", idx), m_raddr, (ro < 0) ? '0 : port_addr(ro));
      chk($sformatf("v%0d m_rlen", idx), m_rlen, (ro < 0) ? '0 : lens[ro]);
      tick();
   endtask

   initial begin
      bit            mwb, mrb;
      int            mwo, mwp, mro, mrp, g;
      logic [N-1:0]  wreq, rreq, e_wg, e_rg, e_rdy, e_last;
      bit            nwb, nrb;

      lens[0] = 8'd3; lens[1] = 8'd3; lens[2] = 8'd1; lens[3] = 8'd0;
      // Three writers with single-beat bursts rotate 0,2,3 with an idle cycle between.
      tbl[0]  = '{4'b1101, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[1]  = '{4'b1101, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
      tbl[2]  = '{4'b1101, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[3]  = '{4'b1101, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
      tbl[4]  = '{4'b1101, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[5]  = '{4'b1101, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b1000};
      tbl[6]  = '{4'b1101, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[7]  = '{4'b1101, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
      // Port 1 writes while port 2 reads: both channels granted together.
      tbl[8]  = '{4'b0110, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[9]  = '{4'b0110, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0100, 4'b0110, 4'b0000};
      tbl[10] = '{4'b0110, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010, 4'b0100, 4'b0110, 4'b0100};
      tbl[11] = '{4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
      tbl[12] = '{4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
      tbl[13] = '{4'b0000, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

      m_rdata = 32'h1234_5678;
      load_ports();
      rst = 1'b0;
      drive(4'b1111, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      tick();
      #2;
      chk("rst w_busy", w_busy, 0);
      chk("rst r_busy", r_busy, 0);
      chk("rst w_grant", w_grant, 0);
      chk("rst r_grant", r_grant, 0);
      chk("rst s_ready", s_ready, 0);
      chk("rst s_last", s_last, 0);
      chk("rst m_wvalid", m_wvalid, 0);
      chk("rst m_rvalid", m_rvalid, 0);
      chk("rst m_waddr", m_waddr, 0);
      chk("rst s_rdata", s_rdata, 32'h1234_5678);

      do_reset();
      for (int i = 0; i < 8; i++) run_vec(i);
      do_reset();
      for (int i = 8; i < 14; i++) run_vec(i);

      // Downstream stall mid-burst keeps valid and grant, withholds ready.
      do_reset();
      drive(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0); #2; tick();
      #2; chk("stall beat1 grant", w_grant, 4'b0001); tick();
      drive(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #2;
         chk($sformatf("stall%0d m_wvalid", c), m_wvalid, 1);
         chk($sformatf("stall%0d s_ready", c), s_ready, 0);
         chk($sformatf("stall%0d w_grant", c), w_grant, 4'b0001);
         tick();
      end
      drive(4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0); #2;
      chk("stall end s_ready", s_ready, 4'b0001);
      chk("stall end s_last", s_last, 4'b0001);
      tick();
      drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
      chk("stall end idle", w_busy, 0);

      // Requester drops valid mid-burst; a last flag without valid must not end it.
      do_reset();
      drive(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0); #2; tick();
      #2; chk("drop beat1 m_wvalid", m_wvalid, 1); tick();
      drive(4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0); #2;
      chk("drop m_wvalid", m_wvalid, 0);
      chk("drop lock", w_grant, 4'b0001);
      tick();
      drive(4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0); #2;
      chk("resume lock", w_grant, 4'b0001);
      chk("resume m_wvalid", m_wvalid, 1);
      chk("resume s_last", s_last, 4'b0001);
      tick();
      drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
      chk("resume idle", w_busy, 0);

      // Asynchronous reset mid read burst, then the pointer restarts at port 0.
      do_reset();
      drive(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0); #2; tick();
      #2; chk("arst pre r_grant", r_grant, 4'b0010);
      rst = 1'b0;
      #1;
      chk("arst r_busy", r_busy, 0);
      chk("arst m_rvalid", m_rvalid, 0);
      chk("arst r_grant", r_grant, 0);
      chk("arst s_ready", s_ready, 0);
      drive(4'b1010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      rst = 1'b1;
      #2; chk("arst release idle", r_busy, 0); tick();
      #2; chk("arst ptr0 grant", r_grant, 4'b0010);

      // Write owner switching to a read request is held off until its write ends.
      do_reset();
      drive(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0); #2; tick();
      drive(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0); #2;
      chk("mask w_grant", w_grant, 4'b1000); tick();
      #2; chk("mask r_busy", r_busy, 0); tick();
      drive(4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0); #2;
      chk("mask r_grant", r_grant, 0);
      chk("mask w_last", s_last, 4'b1000);
      tick();
      drive(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0); #2;
      chk("mask w idle", w_busy, 0);
      chk("mask r still idle", r_busy, 0);
      tick();
      #2;
      chk("mask r granted", r_grant, 4'b1000);
      chk("mask w stays idle", w_grant, 0);

      // Random traffic against a rule-level model of both channels.
      do_reset();
      mwb = 0; mrb = 0; mwo = 0; mro = 0; mwp = 0; mrp = 0;
      for (int c = 0; c < 400; c++) begin
         s_valid = N'($urandom);
         for (int i = 0; i < N; i++) begin
            s_wstrb[i*SW +: SW] = ($urandom_range(0, 2) == 0) ? '0 : SW'($urandom);
            s_addr[i*AW +: AW]  = AW'($urandom);
            s_wdata[i*DW +: DW] = DW'($urandom);
            s_len[i*LW +: LW]   = LW'($urandom);
         end
         m_wready = ($urandom_range(0, 3) != 0);
         m_rready = ($urandom_range(0, 3) != 0);
         m_wlast  = ($urandom_range(0, 2) == 0);
         m_rlast  = ($urandom_range(0, 2) == 0);
         m_rdata  = DW'($urandom);
         #2;
         e_wg = '0; e_rg = '0; e_rdy = '0; e_last = '0;
         if (mwb) begin
            e_wg[mwo] = 1'b1; e_rdy[mwo] = m_wready; e_last[mwo] = m_wlast;
         end
         if (mrb) begin
            e_rg[mro] = 1'b1; e_rdy[mro] = e_rdy[mro] | m_rready; e_last[mro] = e_last[mro] | m_rlast;
         end
         chk("rnd w_grant", w_grant, e_wg);
         chk("rnd r_grant", r_grant, e_rg);
         chk("rnd s_ready", s_ready, e_rdy);
         chk("rnd s_last", s_last, e_last);
         chk("rnd m_wvalid", m_wvalid, mwb ? s_valid[mwo] : 1'b0);
         chk("rnd m_rvalid", m_rvalid, mrb ? s_valid[mro] : 1'b0);
         chk("rnd m_waddr", m_waddr, mwb ? s_addr[mwo*AW +: AW] : '0);
         chk("rnd m_wdata", m_wdata, mwb ? s_wdata[mwo*DW +: DW] : '0);
         chk("rnd m_wstrb", m_wstrb, mwb ? s_wstrb[mwo*SW +: SW] : '0);
         chk("rnd m_wlen", m_wlen, mwb ? s_len[mwo*LW +: LW] : '0);
         chk("rnd m_raddr", m_raddr, mrb ? s_addr[mro*AW +: AW] : '0);
         chk("rnd m_rlen", m_rlen, mrb ? s_len[mro*LW +: LW] : '0);
         chk("rnd s_rdata", s_rdata, m_rdata);
         for (int i = 0; i < N; i++) begin
            wreq[i] = s_valid[i] && (s_wstrb[i*SW +: SW] != '0) && !(mrb && mro == i);
            rreq[i] = s_valid[i] && (s_wstrb[i*SW +: SW] == '0) && !(mwb && mwo == i);
         end
         nwb = mwb; nrb = mrb;
         if (!mwb) begin
            g = pick(wreq, mwp);
            if (g >= 0) begin nwb = 1; mwo = g; mwp = (g + 1) % N; end
         end else if (s_valid[mwo] && m_wready && m_wlast) nwb = 0;
         if (!mrb) begin
            g = pick(rreq, mrp);
            if (g >= 0) begin nrb = 1; mro = g; mrp = (g + 1) % N; end
         end else if (s_valid[mro] && m_rready && m_rlast) nrb = 0;
         mwb = nwb; mrb = nrb;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
